// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    localparam int unsigned DefNLines = 16;
    localparam int unsigned DefNWords = 4;

    // Field widths of a 32-bit byte address: {tag, index, word offset, 2'b byte}
    function automatic int unsigned off_width(input int unsigned nwords);
        return $clog2(nwords);
    endfunction

    function automatic int unsigned idx_width(input int unsigned nlines);
        return $clog2(nlines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned nlines, input int unsigned nwords);
        return 32 - 2 - $clog2(nlines) - $clog2(nwords);
    endfunction

    localparam int unsigned DefOffW = off_width(DefNWords);
    localparam int unsigned DefIdxW = idx_width(DefNLines);
    localparam int unsigned DefTagW = tag_width(DefNLines, DefNWords);

endpackage

// File: rtl/icache_array.sv
// Data, tag and valid storage for the icache: async read, sync write, sync valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned NLINES = DefNLines,
    parameter int unsigned NWORDS = DefNWords
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic [idx_width(NLINES)-1:0]     rd_idx,
    input  logic [off_width(NWORDS)-1:0]     rd_off,
    output logic [31:0]                      rd_data,
    output logic [tag_width(NLINES,NWORDS)-1:0] rd_tag,
    output logic                             rd_valid,
    input  logic                             wr_en,
    input  logic [idx_width(NLINES)-1:0]     wr_idx,
    input  logic [off_width(NWORDS)-1:0]     wr_off,
    input  logic [31:0]                      wr_data,
    input  logic                             tag_we,
    input  logic [tag_width(NLINES,NWORDS)-1:0] wr_tag
);

    localparam int unsigned TagW = tag_width(NLINES, NWORDS);

    logic [31:0]     data_mem [NLINES][NWORDS];
    logic [TagW-1:0] tag_mem  [NLINES];
    logic [NLINES-1:0] valid_q, valid_d;

    assign rd_data  = data_mem[rd_idx][rd_off];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    // A line becomes valid only together with its tag write (after its last word).
    always_comb begin
        valid_d = valid_q;
        if (tag_we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits clear in one cycle; clear wins over a simultaneous set.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag storage is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a blocking line fill.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned NLINES = DefNLines,
    parameter int unsigned NWORDS = DefNWords
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        stallI,
    output logic [31:0] memaddr,
    output logic        memreq,
    input  logic [31:0] memrdata,
    input  logic        memvalid
);

    localparam int unsigned OffW = off_width(NWORDS);
    localparam int unsigned IdxW = idx_width(NLINES);
    localparam int unsigned TagW = tag_width(NLINES, NWORDS);
    localparam logic [OffW-1:0] LastWord = OffW'(NWORDS - 1);

    state_e          state_q, state_d;
    logic [OffW-1:0] cnt_q, cnt_d;
    logic [TagW-1:0] miss_tag_q, miss_tag_d;
    logic [IdxW-1:0] miss_idx_q, miss_idx_d;

    logic [TagW-1:0] pc_tag;
    logic [IdxW-1:0] pc_idx;
    logic [OffW-1:0] pc_off;
    logic [31:0]     rd_data;
    logic [TagW-1:0] rd_tag;
    logic            rd_valid;
    logic            hit;
    logic            fill_we;
    logic            fill_last;
    logic            unused_byte_off;

    assign pc_tag          = pcF[31 -: TagW];
    assign pc_idx          = pcF[2 + OffW +: IdxW];
    assign pc_off          = pcF[2 +: OffW];
    assign unused_byte_off = ^pcF[1:0];

    assign hit     = (state_q == StIdle) && rd_valid && (rd_tag == pc_tag);
    assign stallI  = ~hit;
    assign instrF  = hit ? rd_data : 32'h0000_0000;
    assign memreq  = (state_q == StFill);
    assign memaddr = memreq ? {miss_tag_q, miss_idx_q, cnt_q, 2'b00} : 32'h0000_0000;

    // Next-state, counter and miss-register update; array writes decoded here.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        fill_we    = 1'b0;
        fill_last  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!hit) begin
                    miss_tag_d = pc_tag;
                    miss_idx_d = pc_idx;
                    cnt_d      = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (memvalid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastWord) begin
                        fill_last = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and fill bookkeeping; reset aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    icache_array #(
        .NLINES (NLINES),
        .NWORDS (NWORDS)
    ) u_array (
        .clk      (clk),
        .clr      (reset),
        .rd_idx   (pc_idx),
        .rd_off   (pc_off),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (fill_we & ~reset),
        .wr_idx   (miss_idx_q),
        .wr_off   (cnt_q),
        .wr_data  (memrdata),
        .tag_we   (fill_last & ~reset),
        .wr_tag   (miss_tag_q)
    );

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (default geometry: 16 lines x 4 words).
module tb_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        stallI;
    logic [31:0] memaddr;
    logic        memreq;
    logic [31:0] memrdata;
    logic        memvalid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icache #(
        .NLINES (16),
        .NWORDS (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pcF      (pcF),
        .instrF   (instrF),
        .stallI   (stallI),
        .memaddr  (memaddr),
        .memreq   (memreq),
        .memrdata (memrdata),
        .memvalid (memvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the IDLE cycle that detects the miss; returns in the first hit cycle.
    task automatic do_fill(input string name, input logic [31:0] base, input logic [31:0] dbase,
                           input int waits, input int exp_stalls);
        int stalls;
        stalls = 0;
        chk({name, "_miss_stall"}, {31'b0, stallI}, 32'd1);
        chk({name, "_miss_nop"}, instrF, 32'h0);
        if (stallI) stalls++;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < waits; k++) begin
                tick();
                memvalid = 1'b0;
                #1;
                chk({name, "_wait_addr"}, memaddr, base + 32'(4 * w));
                chk({name, "_wait_req"}, {31'b0, memreq}, 32'd1);
                if (stallI) stalls++;
            end
            tick();
            memvalid = 1'b1;
            memrdata = dbase + 32'(w);
            #1;
            chk({name, "_addr"}, memaddr, base + 32'(4 * w));
            chk({name, "_req"}, {31'b0, memreq}, 32'd1);
            if (stallI) stalls++;
        end
        tick();
        memvalid = 1'b0;
        memrdata = 32'h0;
        #1;
        chk({name, "_done_req"}, {31'b0, memreq}, 32'd0);
        chk({name, "_done_nop"}, instrF, 32'h0);
        if (stallI) stalls++;
        tick();
        #1;
        if (stallI) stalls++;
        chk({name, "_hit_stall"}, {31'b0, stallI}, 32'd0);
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        pcF      = 32'h0000_0040;
        memrdata = 32'h0;
        memvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        // Reset state: idle, everything invalid, no request.
        chk("rst_memreq", {31'b0, memreq}, 32'd0);
        chk("rst_memaddr", memaddr, 32'h0);

        // Cold miss at 0x40, memory answers every cycle.
        do_fill("cold", 32'h0000_0040, 32'h0000_00A0, 0, 6);
        chk("cold_instr", instrF, 32'h0000_00A0);

        // Same-line hits, same cycle.
        for (int w = 1; w < 4; w++) begin
            pcF = 32'h0000_0040 + 32'(4 * w);
            #1;
            chk("line_hit", instrF, 32'h0000_00A0 + 32'(w));
            chk("line_hit_req", {31'b0, memreq}, 32'd0);
        end

        // Second line (index 8) with one wait state per word.
        pcF = 32'h0000_0080;
        #1;
        do_fill("idx8", 32'h0000_0080, 32'h0000_00D0, 1, 10);
        chk("idx8_instr", instrF, 32'h0000_00D0);

        // Stray memvalid while idle and hitting.
        pcF = 32'h0000_0044;
        #1;
        memvalid = 1'b1;
        memrdata = 32'hDEAD_BEEF;
        #1;
        chk("stray_instr", instrF, 32'h0000_00A1);
        tick();
        memvalid = 1'b0;
        memrdata = 32'h0;
        #1;
        chk("stray_after", instrF, 32'h0000_00A1);
        chk("stray_stall", {31'b0, stallI}, 32'd0);
        for (int w = 0; w < 4; w++) begin
            pcF = 32'h0000_0040 + 32'(4 * w);
            #1;
            chk("stray_line", instrF, 32'h0000_00A0 + 32'(w));
        end

        // Conflict on index 4 with tag 1.
        pcF = 32'h0000_0140;
        #1;
        do_fill("conf", 32'h0000_0140, 32'h0000_00B0, 0, 6);
        chk("conf_instr", instrF, 32'h0000_00B0);
        pcF = 32'h0000_014C;
        #1;
        chk("conf_last", instrF, 32'h0000_00B3);
        pcF = 32'h0000_0084;
        #1;
        chk("other_line", instrF, 32'h0000_00D1);

        // Old tag now misses; refill with three wait states per word.
        pcF = 32'h0000_0040;
        #1;
        do_fill("wait3", 32'h0000_0040, 32'h0000_00C0, 3, 18);
        for (int w = 0; w < 4; w++) begin
            pcF = 32'h0000_0040 + 32'(4 * w);
            #1;
            chk("wait3_word", instrF, 32'h0000_00C0 + 32'(w));
        end

        // Reset in the cycle after the second word of a fill to index 0.
        pcF = 32'h0000_0200;
        #1;
        chk("mid_miss", {31'b0, stallI}, 32'd1);
        tick();
        memvalid = 1'b1;
        memrdata = 32'h0000_00E0;
        #1;
        chk("mid_addr0", memaddr, 32'h0000_0200);
        tick();
        memrdata = 32'h0000_00E1;
        #1;
        chk("mid_addr1", memaddr, 32'h0000_0204);
        tick();
        reset    = 1'b1;
        memrdata = 32'h0000_00E2;
        #1;
        chk("mid_rst_req", {31'b0, memreq}, 32'd1);
        tick();
        reset    = 1'b0;
        memvalid = 1'b0;
        memrdata = 32'h0;
        pcF      = 32'h0000_0040;
        #1;
        chk("post_rst_req", {31'b0, memreq}, 32'd0);
        chk("post_rst_addr", memaddr, 32'h0);
        do_fill("refetch", 32'h0000_0040, 32'h0000_00F0, 0, 6);
        chk("refetch_instr", instrF, 32'h0000_00F0);
        pcF = 32'h0000_0200;
        #1;
        chk("partial_invalid", {31'b0, stallI}, 32'd1);
        chk("partial_nop", instrF, 32'h0);
        pcF = 32'h0000_0084;
        #1;
        chk("rst_cleared", {31'b0, stallI}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
